// File: rtl/spi_master_driver.sv
// -----------------------------------------------------------------------------
// spi_master_driver
//
// Turns parallel command requests into framed serial transactions for the SPI
// slave + RAM subsystem and collects read-back bytes from MISO. Slave and
// master share the system clock, so one serial bit moves per clock cycle.
//
// Frame layout (11 bits, MSB first on MOSI):
//   bit 0     : read/write selector (cmd_type[1])
//   bits 1..10: {cmd_type, cmd_data}, the word the slave presents as rx_data
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_cmd_valid  command request
//   o_cmd_ready  command accepted when high (IDLE and not in reset)
//   i_cmd_type   00 wr addr, 01 wr data, 10 rd addr, 11 rd data
//   i_cmd_data   address or data byte
//   o_rsp_valid  one-cycle pulse, read byte available
//   o_rsp_data   received byte, held until the next read-data frame completes
//   o_busy       high in every state other than IDLE
//   o_mosi       serial data to slave
//   o_ss_n       slave select, active low
//   i_miso       serial data from slave (only sampled in RECV)
//
// Parameters:
//   RD_LATENCY   cycles between last MOSI bit and first MISO data cycle (0..7)
//   IDLE_GAP     minimum ss_n high cycles between frames (1..7)
// -----------------------------------------------------------------------------
module spi_master_driver #(
    parameter int RD_LATENCY = 2,
    parameter int IDLE_GAP   = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd_type,
    input  logic [7:0] i_cmd_data,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_data,
    output logic       o_busy,
    output logic       o_mosi,
    output logic       o_ss_n,
    input  logic       i_miso
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RECV  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Counter reload values: each state counts down to zero on its last cycle.
    localparam logic [3:0] LP_SHIFT_LOAD = 4'd10;
    localparam logic [3:0] LP_RECV_LOAD  = 4'd7;
    localparam logic [3:0] LP_WAIT_LOAD  = 4'(RD_LATENCY - 1);
    localparam logic [3:0] LP_GAP_LOAD   = 4'(IDLE_GAP - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [9:0]  r_sh;          // frame bits 1..10 still to go out
    logic        r_rd;          // current frame is a read-data frame
    logic [6:0]  r_rx;          // first 7 MISO samples; the 8th goes straight to rsp_data
    logic        r_mosi;
    logic        r_ss_n;
    logic        r_busy;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_data;

    state_t      w_state_nx;
    logic [3:0]  w_cnt_nx;
    logic [9:0]  w_sh_nx;
    logic        w_rd_nx;
    logic [6:0]  w_rx_nx;
    logic        w_mosi_nx;
    logic        w_ss_n_nx;
    logic        w_busy_nx;
    logic        w_rsp_valid_nx;
    logic [7:0]  w_rsp_data_nx;
    logic        w_accept;

    // Ready is combinational so it is low during reset yet high on the very
    // first cycle after release.
    assign o_cmd_ready = (r_state == ST_IDLE) && !i_rst;
    assign w_accept    = i_cmd_valid && o_cmd_ready;

    assign o_mosi      = r_mosi;
    assign o_ss_n      = r_ss_n;
    assign o_busy      = r_busy;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_sh_nx        = r_sh;
        w_rd_nx        = r_rd;
        w_rx_nx        = r_rx;
        w_mosi_nx      = 1'b0;
        w_rsp_valid_nx = 1'b0;
        w_rsp_data_nx  = r_rsp_data;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nx = ST_SHIFT;
                    w_cnt_nx   = LP_SHIFT_LOAD;
                    w_sh_nx    = {i_cmd_type, i_cmd_data};
                    w_rd_nx    = (i_cmd_type == 2'b11);
                    // Bit 0 of the frame goes out in the first SHIFT cycle.
                    w_mosi_nx  = i_cmd_type[1];
                end else begin
                    w_cnt_nx   = 4'd0;
                end
            end
            ST_SHIFT: begin
                w_sh_nx = {r_sh[8:0], 1'b0};
                if (r_cnt != 4'd0) begin
                    w_cnt_nx  = r_cnt - 4'd1;
                    w_mosi_nx = r_sh[9];
                end else if (!r_rd) begin
                    w_state_nx = ST_GAP;
                    w_cnt_nx   = LP_GAP_LOAD;
                end else if (RD_LATENCY == 0) begin
                    w_state_nx = ST_RECV;
                    w_cnt_nx   = LP_RECV_LOAD;
                end else begin
                    w_state_nx = ST_WAIT;
                    w_cnt_nx   = LP_WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nx = r_cnt - 4'd1;
                end else begin
                    w_state_nx = ST_RECV;
                    w_cnt_nx   = LP_RECV_LOAD;
                end
            end
            ST_RECV: begin
                w_rx_nx = {r_rx[5:0], i_miso};
                if (r_cnt != 4'd0) begin
                    w_cnt_nx = r_cnt - 4'd1;
                end else begin
                    w_state_nx     = ST_GAP;
                    w_cnt_nx       = LP_GAP_LOAD;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_data_nx  = {r_rx, i_miso};
                end
            end
            ST_GAP: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nx = r_cnt - 4'd1;
                end else begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = 4'd0;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = 4'd0;
            end
        endcase

        // Select is low for the whole frame body: command, wait and receive.
        w_ss_n_nx = !((w_state_nx == ST_SHIFT) || (w_state_nx == ST_WAIT) ||
                      (w_state_nx == ST_RECV));
        w_busy_nx = (w_state_nx != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_sh        <= 10'd0;
            r_rd        <= 1'b0;
            r_rx        <= 7'd0;
            r_mosi      <= 1'b0;
            r_ss_n      <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_sh        <= w_sh_nx;
            r_rd        <= w_rd_nx;
            r_rx        <= w_rx_nx;
            r_mosi      <= w_mosi_nx;
            r_ss_n      <= w_ss_n_nx;
            r_busy      <= w_busy_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_data  <= w_rsp_data_nx;
        end
    end

endmodule

// File: tb/tb_spi_master_driver.sv
// -----------------------------------------------------------------------------
// tb_spi_master_driver
//
// Directed bench for spi_master_driver (RD_LATENCY=2, IDLE_GAP=1). A small
// behavioural SPI slave + RAM stub decodes MOSI frames and answers read-data
// frames on MISO, driving 1s outside the data window. All sampling and
// driving happens on the falling clock edge; cycle c is the cycle ending at
// accept edge E + c.
// -----------------------------------------------------------------------------
module tb_spi_master_driver;

    localparam int LAT = 2;
    localparam int GAP = 1;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       mosi;
    logic       ss_n;
    logic       miso;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave stub state
    logic [7:0]  stub_mem [256];
    logic [7:0]  stub_waddr;
    logic [7:0]  stub_raddr;
    logic [10:0] stub_frame;
    logic [10:0] stub_last;
    logic [7:0]  stub_byte;
    int          stub_cyc;
    bit          stub_rd;
    int          rsp_cnt;

    spi_master_driver #(.RD_LATENCY(LAT), .IDLE_GAP(GAP)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_type  (cmd_type),
        .i_cmd_data  (cmd_data),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_busy      (busy),
        .o_mosi      (mosi),
        .o_ss_n      (ss_n),
        .i_miso      (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slave: counts frame cycles, decodes 11-bit frames, returns
    // mem[raddr] MSB-first in cycles 12+LAT..19+LAT of a read-data frame.
    initial begin
        for (int i = 0; i < 256; i++) stub_mem[i] = 8'h00;
        stub_waddr = 8'h00; stub_raddr = 8'h00; stub_frame = 11'h000;
        stub_last = 11'h000; stub_cyc = 0; stub_rd = 1'b0; rsp_cnt = 0;
        miso = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) rsp_cnt = rsp_cnt + 1;
            if (ss_n === 1'b0) begin
                stub_cyc = stub_cyc + 1;
                if (stub_cyc <= 11) begin
                    stub_frame = {stub_frame[9:0], mosi};
                    if (stub_cyc == 11) begin
                        stub_last = stub_frame;
                        case (stub_frame[9:8])
                            2'b00:   stub_waddr = stub_frame[7:0];
                            2'b01:   stub_mem[stub_waddr] = stub_frame[7:0];
                            2'b10:   stub_raddr = stub_frame[7:0];
                            default: stub_rd = 1'b1;
                        endcase
                    end
                end
                if (stub_rd && stub_cyc >= 12 + LAT && stub_cyc <= 19 + LAT) begin
                    stub_byte = stub_mem[stub_raddr];
                    miso = stub_byte[3'(19 + LAT - stub_cyc)];
                end else begin
                    miso = 1'b1;
                end
            end else begin
                stub_cyc = 0;
                stub_rd  = 1'b0;
                miso     = 1'b0;
            end
        end
    end

    // Waits for ready and presents a command; returns at the negedge of
    // cycle 0 with cmd_valid high (accept happens at the next rising edge).
    task automatic send_cmd(input logic [1:0] t, input logic [7:0] d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                cmd_type  = t;
                cmd_data  = d;
                cmd_valid = 1'b1;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1; cmd_valid = 1'b1; cmd_type = 2'b00; cmd_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({ss_n, mosi, cmd_ready, rsp_valid, busy} !== 5'b10000) begin
                n_fail++;
                $display("FAIL reset_outputs: ss_n/mosi/ready/rsp_valid/busy got %b want 10000",
                         {ss_n, mosi, cmd_ready, rsp_valid, busy});
            end
            n_checks++;
            if (rsp_data !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_rsp_data: got %h want 00", rsp_data);
            end
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after_release: got %b want 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if ({ss_n, busy, cmd_ready} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_first_accept: ss_n/busy/ready got %b want 010", {ss_n, busy, cmd_ready});
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL reset_idle_timeout: got 0 want 1"); end
    endtask

    task automatic test_write_addr();
        bit ok;
        logic [10:0] exp_frame;
        logic exp_mosi, exp_ss, exp_rdy, exp_busy;
        exp_frame = 11'b000_0101_1010;
        send_cmd(2'b00, 8'h5A, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wa_send_timeout: got 0 want 1"); end
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            exp_mosi = (c <= 11) ? exp_frame[11 - c] : 1'b0;
            exp_ss   = (c <= 11) ? 1'b0 : 1'b1;
            exp_rdy  = (c == 13);
            exp_busy = (c <= 12);
            n_checks++;
            if ({mosi, ss_n, cmd_ready, busy, rsp_valid} !== {exp_mosi, exp_ss, exp_rdy, exp_busy, 1'b0}) begin
                n_fail++;
                $display("FAIL wa_cycle%0d: mosi/ss_n/ready/busy/rsp_valid got %b want %b", c,
                         {mosi, ss_n, cmd_ready, busy, rsp_valid},
                         {exp_mosi, exp_ss, exp_rdy, exp_busy, 1'b0});
            end
        end
        n_checks++;
        if (stub_last !== exp_frame) begin
            n_fail++;
            $display("FAIL wa_frame: got %h want %h", stub_last, exp_frame);
        end
    endtask

    task automatic test_read_data();
        bit ok;
        int start_cnt;
        logic [10:0] exp_frame;
        logic exp_mosi, exp_ss, exp_rdy, exp_rv;
        stub_mem[8'h5A] = 8'hC3;
        send_cmd(2'b10, 8'h5A, ok);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle(ok);
        start_cnt = rsp_cnt;
        exp_frame = 11'b111_0000_0000;
        send_cmd(2'b11, 8'h00, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rd_send_timeout: got 0 want 1"); end
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            exp_mosi = (c <= 11) ? exp_frame[11 - c] : 1'b0;
            exp_ss   = (c <= 21) ? 1'b0 : 1'b1;
            exp_rv   = (c == 22);
            exp_rdy  = (c == 23);
            n_checks++;
            if ({mosi, ss_n, rsp_valid, cmd_ready} !== {exp_mosi, exp_ss, exp_rv, exp_rdy}) begin
                n_fail++;
                $display("FAIL rd_cycle%0d: mosi/ss_n/rsp_valid/ready got %b want %b", c,
                         {mosi, ss_n, rsp_valid, cmd_ready}, {exp_mosi, exp_ss, exp_rv, exp_rdy});
            end
            if (c == 22) begin
                n_checks++;
                if (rsp_data !== 8'hC3) begin
                    n_fail++;
                    $display("FAIL rd_rsp_data: got %h want c3", rsp_data);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (rsp_cnt - start_cnt !== 1) begin
            n_fail++;
            $display("FAIL rd_pulse_count: got %0d want 1", rsp_cnt - start_cnt);
        end
    endtask

    task automatic test_full_loop();
        bit ok;
        int start_cnt;
        logic [1:0] types [3];
        logic [7:0] datas [3];
        types = '{2'b00, 2'b01, 2'b10};
        datas = '{8'h10, 8'hA7, 8'h10};
        start_cnt = rsp_cnt;
        for (int k = 0; k < 3; k++) begin
            send_cmd(types[k], datas[k], ok);
            @(negedge clk);
            cmd_valid = 1'b0;
            wait_idle(ok);
        end
        n_checks++;
        if (rsp_cnt !== start_cnt) begin
            n_fail++;
            $display("FAIL loop_no_rsp: got %0d pulses want 0", rsp_cnt - start_cnt);
        end
        n_checks++;
        if (stub_mem[8'h10] !== 8'hA7) begin
            n_fail++;
            $display("FAIL loop_ram_write: got %h want a7", stub_mem[8'h10]);
        end
        send_cmd(2'b11, 8'h00, ok);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL loop_idle_timeout: got 0 want 1"); end
        n_checks++;
        if (rsp_data !== 8'hA7 || rsp_cnt - start_cnt !== 1) begin
            n_fail++;
            $display("FAIL loop_readback: got %h (%0d pulses) want a7 (1 pulse)", rsp_data, rsp_cnt - start_cnt);
        end
    endtask

    task automatic test_busy_hold();
        bit ok;
        logic exp_ss, exp_rdy;
        send_cmd(2'b00, 8'h3C, ok);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cmd_type = 2'b01;
                cmd_data = 8'hFF;
            end
            exp_ss  = (c <= 11 || c == 14) ? 1'b0 : 1'b1;
            exp_rdy = (c == 13);
            n_checks++;
            if ({ss_n, cmd_ready} !== {exp_ss, exp_rdy}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: ss_n/ready got %b want %b", c, {ss_n, cmd_ready}, {exp_ss, exp_rdy});
            end
            if (c == 12) begin
                n_checks++;
                if (stub_last !== 11'b000_0011_1100) begin
                    n_fail++;
                    $display("FAIL hold_captured_frame: got %h want 03c", stub_last);
                end
            end
        end
        cmd_valid = 1'b0;
        wait_idle(ok);
        n_checks++;
        if (stub_last !== 11'b001_1111_1111) begin
            n_fail++;
            $display("FAIL hold_second_frame: got %h want 1ff", stub_last);
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        int start_cnt;
        logic [10:0] exp_frame;
        send_cmd(2'b10, 8'h10, ok);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle(ok);
        start_cnt = rsp_cnt;
        send_cmd(2'b11, 8'h00, ok);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 1)  cmd_valid = 1'b0;
            if (c == 16) rst = 1'b1;
        end
        n_checks++;
        if ({ss_n, mosi, rsp_valid, busy} !== 4'b1000 || rsp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_outputs: ss_n/mosi/rsp_valid/busy=%b rsp_data=%h want 1000 00",
                     {ss_n, mosi, rsp_valid, busy}, rsp_data);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (rsp_cnt !== start_cnt || rsp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_no_rsp: pulses=%0d rsp_data=%h want 0 00", rsp_cnt - start_cnt, rsp_data);
        end
        exp_frame = 11'b000_0101_1010;
        send_cmd(2'b00, 8'h5A, ok);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            n_checks++;
            if ({ss_n, mosi} !== {1'b0, exp_frame[11 - c]}) begin
                n_fail++;
                $display("FAIL midrst_restart_cycle%0d: ss_n/mosi got %b want %b", c,
                         {ss_n, mosi}, {1'b0, exp_frame[11 - c]});
            end
        end
        wait_idle(ok);
        n_checks++;
        if (stub_last !== exp_frame) begin
            n_fail++;
            $display("FAIL midrst_restart_frame: got %h want %h", stub_last, exp_frame);
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_data = 8'h00;
        test_reset();
        test_write_addr();
        test_read_data();
        test_full_loop();
        test_busy_hold();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
